// File: rtl/hbridge_deadtime_pkg.sv
// Shared types and defaults for the H-bridge dead-time stage.
package hbridge_deadtime_pkg;

  // Per-leg gate-drive state
  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_DEAD = 2'd1,
    LEG_HIGH = 2'd2,
    LEG_LOW  = 2'd3
  } leg_state_e;

  // 500 ns at a 100 MHz sclk
  localparam int DEAD_CYC_DEF = 50;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/hbridge_deadtime_leg.sv
// One H-bridge leg: Moore FSM with dead-time down-counter.
// Both switches stay off for DEAD_CYC cycles before either gate turns on.
//
//   state | meaning
//   OFF   | killed (disabled or fault); both gates off
//   DEAD  | dead window toward tgt; both gates off, counter running
//   HIGH  | high-side switch on
//   LOW   | low-side switch on
module hbridge_deadtime_leg
  import hbridge_deadtime_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic sclk,
  input  logic s_rst,
  input  logic kill,
  input  logic req,
  output logic hs,
  output logic ls,
  output logic dt_active
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEAD_CYC - 1);

  leg_state_e       state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, target and dead-time counter registers
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q <= LEG_OFF;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; kill overrides every other transition
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (kill) begin
      state_d = LEG_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        LEG_OFF: begin
          state_d = LEG_DEAD;
          tgt_d   = req;
          cnt_d   = CNT_RELOAD;
        end
        LEG_DEAD: begin
          if (req != tgt_q) begin
            // request flipped back mid-window: full window starts over
            tgt_d = req;
            cnt_d = CNT_RELOAD;
          end else if (cnt_q == '0) begin
            state_d = tgt_q ? LEG_HIGH : LEG_LOW;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        LEG_HIGH: begin
          if (!req) begin
            state_d = LEG_DEAD;
            tgt_d   = 1'b0;
            cnt_d   = CNT_RELOAD;
          end
        end
        LEG_LOW: begin
          if (req) begin
            state_d = LEG_DEAD;
            tgt_d   = 1'b1;
            cnt_d   = CNT_RELOAD;
          end
        end
        default: begin
          state_d = LEG_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Gate drives decoded from the state register only, so they clear on async reset
  assign hs        = (state_q == LEG_HIGH);
  assign ls        = (state_q == LEG_LOW);
  assign dt_active = (state_q == LEG_DEAD);

endmodule

// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver with per-leg dead time and latched over-current kill.
module hbridge_deadtime
  import hbridge_deadtime_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [1:0] ma_in,
  input  logic       drv_en,
  input  logic       oc_flt,
  input  logic       fault_clr,
  output logic [1:0] hs,
  output logic [1:0] ls,
  output logic [1:0] dt_active,
  output logic       fault
);

  logic [1:0] ma_q, ma_d;
  logic       flt_meta_q, flt_meta_d;
  logic       flt_s_q, flt_s_d;
  logic       fault_q, fault_d;
  logic       kill;

  // Input capture, fault synchroniser and fault latch registers
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      ma_q       <= 2'b00;
      flt_meta_q <= 1'b0;
      flt_s_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      ma_q       <= ma_d;
      flt_meta_q <= flt_meta_d;
      flt_s_q    <= flt_s_d;
      fault_q    <= fault_d;
    end
  end

  // Next values; a live fault beats a clear in the same cycle
  always_comb begin
    ma_d       = ma_in;
    flt_meta_d = oc_flt;
    flt_s_d    = flt_meta_q;
    fault_d    = fault_q;
    if (flt_s_q) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end
  end

  // flt_s is included so gates drop on the same edge the fault latches
  assign kill  = !drv_en || flt_s_q || fault_q;
  assign fault = fault_q;

  for (genvar g = 0; g < 2; g++) begin : g_leg
    hbridge_deadtime_leg #(
      .DEAD_CYC (DEAD_CYC),
      .CNT_W    (CNT_W)
    ) u_leg (
      .sclk      (sclk),
      .s_rst     (s_rst),
      .kill      (kill),
      .req       (ma_q[g]),
      .hs        (hs[g]),
      .ls        (ls[g]),
      .dt_active (dt_active[g])
    );
  end

endmodule

// File: doc/hbridge_deadtime.md
Name: hbridge_deadtime

Overview:
- Stage directly downstream of the motor PWM generator.
- Consumes its 2-bit complementary leg request and produces the four gate-drive signals of a full H-bridge: a high side and a low side for each leg.
- On every leg switchover, both switches of that leg are held off for a programmable dead time, so shoot-through cannot occur.
- Also latches an over-current fault and gates all switches off while the fault is set.

Parameters:
- DEAD_CYC, 50, dead-time length in sclk cycles (500 ns at 100 MHz); legal range 1 .. 2^CNT_W-1.
- CNT_W, 8, dead-time counter width.

Ports:
- sclk  in  1  system clock.
- s_rst  in  1  reset, asynchronous, active-high.
- ma_in  in  2  leg request from the PWM stage. Bit i = 1: leg i high side; bit i = 0: leg i low side.
- drv_en  in  1  bridge enable. 0 = all switches off (coast).
- oc_flt  in  1  over-current comparator, asynchronous to sclk.
- fault_clr  in  1  single-cycle pulse that clears the latched fault.
- hs  out  2  high-side gate drive per leg.
- ls  out  2  low-side gate drive per leg.
- dt_active  out  2  leg i is inside its dead window.
- fault  out  1  latched over-current fault.

Behaviour:
- Reset (async, active-high): hs=0, ls=0, dt_active=0, fault=0, both legs in OFF, counters 0, sync flops 0.
- Input capture:
  - ma_in is registered once (ma_q).
  - oc_flt passes through a 2-flop synchroniser (flt_s).
- Fault latch:
  - Set when flt_s=1.
  - Cleared when fault_clr=1 and flt_s=0.
  - Set wins over clear when both occur in the same cycle.
- Kill condition: kill = !drv_en | flt_s | fault.
- Per-leg Moore FSM, one instance per leg. Outputs are decoded from the state register; req = ma_q[i].
  - OFF: hs=ls=0. If !kill, go to DEAD with tgt=req and cnt=DEAD_CYC-1.
  - DEAD: hs=ls=0, dt_active=1.
    - If req != tgt: tgt=req and cnt reloads to DEAD_CYC-1 (restart).
    - Else if cnt==0: go to HIGH when tgt=1, LOW when tgt=0.
    - Else cnt decrements.
  - HIGH: hs=1. If req=0, go to DEAD with tgt=0 and cnt reload.
  - LOW: ls=1. If req=1, go to DEAD with tgt=1 and cnt reload.
  - kill=1 forces OFF from any state and takes priority over all other transitions.
- Timing:
  - ma_in edge sampled at edge k: the old gate is low after edge k+1.
  - The new gate is high after edge k+1+DEAD_CYC.
  - The dead window is exactly DEAD_CYC cycles, or longer if it restarts.
- Fault latency: oc_flt rising sampled at edge n → all gates low after edge n+2; fault=1 after the same edge.
- Re-entry: leaving kill (re-enable or fault clear) always passes OFF→DEAD, so a full dead window precedes any gate turning on.
- Invariants:
  - hs[i] & ls[i] is never 1.
  - No gate rises without a preceding DEAD_CYC-cycle window in which both gates of that leg are low.
- ma_in=2'b00 (the PWM stage's disabled output) gives both low sides on (brake). This is legal.
- Legs are fully independent; simultaneous transitions on both legs are handled in parallel.

Decomposition:
- Shared package:
  - leg state enum (OFF, DEAD, HIGH, LOW, 2-bit).
  - default DEAD_CYC and CNT_W constants.
- One natural sub-module, deadtime_leg: the per-leg FSM plus counter, instantiated twice.
- The top level holds the ma_in register, fault synchroniser, fault latch and kill logic.

Test Plan:
1. Reset mid-operation (DEAD_CYC=4, leg 0 in HIGH): assert s_rst between edges → hs=ls=0 and fault=0 immediately, without waiting for a clock edge.
2. Switchover with DEAD_CYC=4, drv_en=1, ma_in steady 2'b01, then 2'b10 sampled at edge k:
   - hs[0] and ls[1] are low after edge k+1.
   - dt_active=2'b11 for 4 cycles.
   - ls[0] and hs[1] are high after edge k+5.
3. Glitch with DEAD_CYC=4: ma_in[0] 1→0 sampled at edge k, back to 1 sampled at edge k+2:
   - The counter restarts.
   - hs[0] returns high after edge k+7.
   - ls[0] never pulses.
4. Fault:
   - oc_flt high for 1 cycle, sampled at edge n → all gates 0 and fault=1 after edge n+2.
   - fault_clr while oc_flt is still high → fault stays 1.
   - fault_clr after oc_flt is low → fault=0, then 4 dead cycles, then gates follow ma_in.
5. Enable:
   - drv_en 1→0 → all gates 0 after the next edge.
   - drv_en 0→1 with ma_in=2'b00 → 4 dead cycles, then ls=2'b11 (brake).
6. Random test: random ma_in, drv_en and oc_flt for 100k cycles, with assertions checking that hs&ls is never 1 and that every gate rise is preceded by at least DEAD_CYC cycles with both gates of that leg low.
